// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: sample RAM port (enable, write enable, address) driven by capture_ctrl
interface capture_ctrl_if #(
   parameter int AW = 9
);
   logic          en;
   logic          we;
   logic [AW-1:0] addr;
   modport master (output en, we, addr);
   modport slave (input en, we, addr);
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: sample RAM sequencer (adc_clk, decimation, trigger edge, pre/post-trigger capture, dump reads)
// Optional AUTO_TRIG_EN: forces a trigger after AUTO_TIMEOUT writes in ARMED and flags it on auto_trigd.
module capture_ctrl #(
   parameter int DEPTH        = 512,
   parameter int AUTO_TIMEOUT = 4096
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     capture_start,
   input  logic                     trig_src,
   input  logic                     trig_edge,
   input  logic [$clog2(DEPTH)-1:0] trig_pos,
   input  logic [3:0]               decimator,
   input  logic                     trig1,
   input  logic                     trig2,
   input  logic                     dump_rd,
   input  logic [$clog2(DEPTH)-1:0] dump_offset,
   output logic                     adc_clk,
   output logic                     capture_done,
   output logic                     dump_busy,
   output logic                     auto_trigd,
   capture_ctrl_if.master           ram
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CMAX = (AUTO_TIMEOUT > DEPTH) ? AUTO_TIMEOUT : DEPTH;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

   state_t        state_q, state_d;
   logic          adc_clk_q, adc_clk_d, sel_q, sel_d, en_q, en_d, we_q, we_d, auto_q, auto_d;
   logic [1:0]    t1_q, t1_d, t2_q, t2_d;
   logic [8:0]    dec_cnt_q, dec_cnt_d, dec_mask;
   logic [3:0]    dec_q, dec_d;
   logic [AW-1:0] tp_q, tp_d, wr_ptr_q, wr_ptr_d, start_q, start_d, addr_q, addr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick, trig_ev, timeout, wr;

`ifdef AUTO_TRIG_EN
   assign timeout = cnt_q == CW'(AUTO_TIMEOUT);
`else
   assign timeout = 1'b0;
`endif

   // adc_clk toggle, decimated sample tick and synchronized trigger edge detection
   always_comb begin
      adc_clk_d = ~adc_clk_q;
      t1_d      = {t1_q[0], trig1};
      t2_d      = {t2_q[0], trig2};
      sel_d     = trig_src ? t2_q[1] : t1_q[1];
      trig_ev   = trig_edge ? (sel_d & ~sel_q) : (~sel_d & sel_q);
      dec_mask  = 9'((10'd1 << ((dec_q > 4'd9) ? 4'd9 : dec_q)) - 10'd1);
      tick      = adc_clk_q && dec_cnt_q == 9'd0;
      dec_cnt_d = capture_start ? 9'd0 : adc_clk_q ? (dec_cnt_q + 9'd1) & dec_mask : dec_cnt_q;
   end

   // capture sequencing: a single counter tracks fill writes, armed writes and post-trigger writes
   always_comb begin
      state_d  = state_q;
      tp_d     = tp_q;
      dec_d    = dec_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      start_d  = start_q;
      auto_d   = auto_q;
      en_d     = 1'b0;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wr       = tick && (state_q == FILL || state_q == ARMED || state_q == POST);
      if (capture_start) begin
         state_d  = FILL;
         tp_d     = trig_pos;
         dec_d    = decimator;
         wr_ptr_d = '0;
         cnt_d    = '0;
         auto_d   = 1'b0;
      end else begin
         if (wr) begin
            en_d     = 1'b1;
            we_d     = 1'b1;
            addr_d   = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
         end
         case (state_q)
            FILL:
               if (wr && cnt_d == CW'(DEPTH) - CW'(tp_q)) begin
                  state_d = ARMED;
                  cnt_d   = '0;
               end
            ARMED:
               if (trig_ev || timeout) begin
                  state_d = (tp_q == '0) ? DONE : POST;
                  start_d = (tp_q == '0) ? wr_ptr_d : start_q;
                  cnt_d   = '0;
                  auto_d  = ~trig_ev;
               end
            POST:
               if (wr && cnt_d == CW'(tp_q)) begin
                  state_d = DONE;
                  start_d = wr_ptr_d;
               end
            default:
               if (dump_rd) begin
                  en_d   = 1'b1;
                  addr_d = start_q + dump_offset;
               end
         endcase
      end
   end

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         adc_clk_q <= 1'b0;
         t1_q      <= '0;
         t2_q      <= '0;
         sel_q     <= 1'b0;
         dec_cnt_q <= '0;
         dec_q     <= '0;
         tp_q      <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
         start_q   <= '0;
         auto_q    <= 1'b0;
         en_q      <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         adc_clk_q <= adc_clk_d;
         t1_q      <= t1_d;
         t2_q      <= t2_d;
         sel_q     <= sel_d;
         dec_cnt_q <= dec_cnt_d;
         dec_q     <= dec_d;
         tp_q      <= tp_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         start_q   <= start_d;
         auto_q    <= auto_d;
         en_q      <= en_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
      end
   end

   assign adc_clk      = adc_clk_q;
   assign capture_done = state_q == DONE;
   assign dump_busy    = state_q == FILL || state_q == ARMED || state_q == POST;
   assign auto_trigd   = auto_q;
   assign ram.en       = en_q;
   assign ram.we       = we_q;
   assign ram.addr     = addr_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: randomized self-checking bench for capture_ctrl using a write-counting reference model
module tb_capture_ctrl;
   logic       clk = 0, rst_n = 0, capture_start = 0, trig_src = 0, trig_edge = 1;
   logic       trig1 = 0, trig2 = 0, dump_rd = 0;
   logic [8:0] trig_pos = 0, dump_offset = 0;
   logic [3:0] decimator = 0;
   logic       adc_clk, capture_done, dump_busy, auto_trigd;
   int         errors = 0, checks = 0;
   int         wr_n = 0, bad_addr = 0, gaps = 0, gap_bad = 0, exp_gap = 2, stray_rd = 0;
   longint     cyc = 0, last_wr = -1;
   logic [8:0] exp_ptr = 0;
   bit         timed_out = 0;

   capture_ctrl_if bus ();

   capture_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .capture_start (capture_start),
      .trig_src      (trig_src),
      .trig_edge     (trig_edge),
      .trig_pos      (trig_pos),
      .decimator     (decimator),
      .trig1         (trig1),
      .trig2         (trig2),
      .dump_rd       (dump_rd),
      .dump_offset   (dump_offset),
      .adc_clk       (adc_clk),
      .capture_done  (capture_done),
      .dump_busy     (dump_busy),
      .auto_trigd    (auto_trigd),
      .ram           (bus)
   );

   always #5 clk = ~clk;

   // advance to the next falling edge and record RAM traffic into the model counters
   task automatic step();
      @(negedge clk);
      cyc++;
      if (bus.en && !bus.we) stray_rd++;
      if (bus.en && bus.we) begin
         if (bus.addr !== exp_ptr) bad_addr++;
         if (last_wr >= 0) begin
            gaps++;
            if (cyc - last_wr != longint'(exp_gap)) gap_bad++;
         end
         last_wr = cyc;
         exp_ptr++;
         wr_n++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic set_trig(input bit src, input bit edge_);
      trig_src  = src;
      trig_edge = edge_;
      trig1     = ~edge_;
      trig2     = ~edge_;
      idle(4);
   endtask

   task automatic start_cap(input int tp, input int dec);
      trig_pos      = 9'(tp);
      decimator     = 4'(dec);
      capture_start = 1;
      exp_ptr       = 0;
      wr_n          = 0;
      bad_addr      = 0;
      gaps          = 0;
      gap_bad       = 0;
      stray_rd      = 0;
      last_wr       = -1;
      exp_gap       = 2 << ((dec > 9) ? 9 : dec);
      step();
      capture_start = 0;
   endtask

   task automatic wait_writes(input int n);
      int budget = (n - wr_n + 4) * exp_gap;
      while (wr_n < n && budget > 0) begin
         step();
         budget--;
      end
      if (wr_n < n) timed_out = 1;
   endtask

   task automatic wait_done(input int n);
      int budget = (n + 4) * exp_gap;
      while (!capture_done && budget > 0) begin
         step();
         budget--;
      end
      if (!capture_done) timed_out = 1;
   endtask

   task automatic fire(input bit src);
      if (src) trig2 = ~trig2;
      else trig1 = ~trig1;
      repeat (3) step();
   endtask

   task automatic end_test(input string name);
      checks++;
      if (timed_out) begin
         errors++;
         $display("FAIL %s timeout: waited event never arrived", name);
      end
      timed_out = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle(2);
      checks++;
      if ({adc_clk, bus.en, bus.we} !== 3'b000) begin
         errors++;
         $display("FAIL reset_clk_en_we: got %b expected 000", {adc_clk, bus.en, bus.we});
      end
      checks++;
      if (bus.addr !== 9'd0) begin
         errors++;
         $display("FAIL reset_addr: got %0d expected 0", bus.addr);
      end
      checks++;
      if ({capture_done, dump_busy, auto_trigd} !== 3'b000) begin
         errors++;
         $display("FAIL reset_status: got %b expected 000", {capture_done, dump_busy, auto_trigd});
      end
      rst_n = 1;
      idle(3);
   endtask

   task automatic test_capture(input int tp, input int dec, input bit src, input bit edge_);
      int base;
      int off;
      set_trig(src, edge_);
      start_cap(tp, dec);
      checks++;
      if (dump_busy !== 1'b1) begin
         errors++;
         $display("FAIL cap_busy: got %b expected 1", dump_busy);
      end
      wait_writes(512 - tp);
      idle($urandom_range(20, 300));
      fire(src);
      base = wr_n;
      wait_done(tp);
      checks++;
      if (wr_n - base != tp) begin
         errors++;
         $display("FAIL cap_post_writes tp=%0d dec=%0d: got %0d expected %0d", tp, dec, wr_n - base, tp);
      end
      checks++;
      if ({capture_done, dump_busy} !== 2'b10) begin
         errors++;
         $display("FAIL cap_done_busy: got %b expected 10", {capture_done, dump_busy});
      end
      checks++;
      if (bad_addr != 0 || gap_bad != 0) begin
         errors++;
         $display("FAIL cap_write_seq: got bad_addr=%0d bad_gap=%0d expected 0 0", bad_addr, gap_bad);
      end
      off         = $urandom_range(0, 511);
      dump_offset = 9'(off);
      dump_rd     = 1;
      step();
      dump_rd = 0;
      checks++;
      if ({bus.en, bus.we} !== 2'b10 || bus.addr !== 9'(int'(exp_ptr) + off)) begin
         errors++;
         $display("FAIL cap_dump off=%0d: got en=%b we=%b addr=%0d expected en=1 we=0 addr=%0d",
                  off, bus.en, bus.we, bus.addr, 9'(int'(exp_ptr) + off));
      end
      end_test("capture");
   endtask

   task automatic test_decimation();
      set_trig(0, 1);
      start_cap(0, 2);
      wait_writes(6);
      checks++;
      if (gap_bad != 0 || gaps != 5) begin
         errors++;
         $display("FAIL dec2_spacing: got bad=%0d of %0d gaps expected 0 of 5 (8 clk)", gap_bad, gaps);
      end
      start_cap(0, 12);
      wait_writes(3);
      checks++;
      if (gap_bad != 0 || gaps != 2) begin
         errors++;
         $display("FAIL dec12_spacing: got bad=%0d of %0d gaps expected 0 of 2 (1024 clk)", gap_bad, gaps);
      end
      end_test("decimation");
   endtask

   task automatic test_fill_ignore();
      int base;
      set_trig(1, 0);
      start_cap(300, 0);
      wait_writes(50);
      trig2 = 0;
      idle(6);
      trig2 = 1;
      wait_writes(212);
      idle(20);
      trig1 = 0;
      idle(6);
      trig1 = 1;
      idle(700);
      checks++;
      if ({capture_done, dump_busy} !== 2'b01) begin
         errors++;
         $display("FAIL fill_ignore_still_armed: got done,busy=%b expected 01", {capture_done, dump_busy});
      end
      fire(1);
      base = wr_n;
      wait_done(300);
      checks++;
      if (wr_n - base != 300 || capture_done !== 1'b1) begin
         errors++;
         $display("FAIL fill_ignore_post: got writes=%0d done=%b expected 300 1", wr_n - base, capture_done);
      end
      end_test("fill_ignore");
   endtask

   task automatic test_dump();
      int offs[2] = '{450, 511};
      foreach (offs[i]) begin
         dump_offset = 9'(offs[i]);
         dump_rd     = 1;
         step();
         dump_rd = 0;
         checks++;
         if ({bus.en, bus.we} !== 2'b10 || bus.addr !== 9'(int'(exp_ptr) + offs[i])) begin
            errors++;
            $display("FAIL dump_wrap off=%0d: got en=%b we=%b addr=%0d expected en=1 we=0 addr=%0d",
                     offs[i], bus.en, bus.we, bus.addr, 9'(int'(exp_ptr) + offs[i]));
         end
      end
      dump_offset = 9'd5;
      dump_rd     = 1;
      start_cap(100, 0);
      checks++;
      if (bus.en !== 1'b0) begin
         errors++;
         $display("FAIL dump_vs_start: got en=%b expected 0", bus.en);
      end
      idle(40);
      dump_rd = 0;
      checks++;
      if (stray_rd != 0 || bad_addr != 0) begin
         errors++;
         $display("FAIL dump_in_fill: got reads=%0d bad_addr=%0d expected 0 0", stray_rd, bad_addr);
      end
      end_test("dump");
   endtask

   task automatic test_reset_mid();
      set_trig(0, 1);
      start_cap(256, 0);
      wait_writes(256);
      idle(30);
      fire(0);
      idle(20);
      rst_n = 0;
      #1;
      checks++;
      if ({adc_clk, bus.en, bus.we, capture_done, dump_busy, auto_trigd} !== 6'd0 || bus.addr !== 9'd0) begin
         errors++;
         $display("FAIL reset_mid_async: got flags=%b addr=%0d expected 000000 0",
                  {adc_clk, bus.en, bus.we, capture_done, dump_busy, auto_trigd}, bus.addr);
      end
      idle(2);
      rst_n = 1;
      trig1 = 0;
      idle(4);
      dump_offset = 9'd77;
      dump_rd     = 1;
      step();
      dump_rd = 0;
      checks++;
      if ({bus.en, bus.we, dump_busy, capture_done} !== 4'b1000 || bus.addr !== 9'd77) begin
         errors++;
         $display("FAIL reset_mid_idle_dump: got en,we,busy,done=%b addr=%0d expected 1000 77",
                  {bus.en, bus.we, dump_busy, capture_done}, bus.addr);
      end
      end_test("reset_mid");
      test_capture(256, 0, 0, 1);
   endtask

   task automatic test_auto();
      set_trig(0, 1);
      start_cap(10, 0);
`ifdef AUTO_TRIG_EN
      wait_done(502 + 4096 + 10);
      checks++;
      if (wr_n != 502 + 4096 + 10) begin
         errors++;
         $display("FAIL auto_writes: got %0d expected %0d", wr_n, 502 + 4096 + 10);
      end
      checks++;
      if ({capture_done, auto_trigd} !== 2'b11) begin
         errors++;
         $display("FAIL auto_flag: got done,auto=%b expected 11", {capture_done, auto_trigd});
      end
      start_cap(10, 0);
      checks++;
      if (auto_trigd !== 1'b0) begin
         errors++;
         $display("FAIL auto_clear: got %b expected 0", auto_trigd);
      end
`else
      wait_writes(502 + 10000);
      checks++;
      if ({capture_done, dump_busy, auto_trigd} !== 3'b010) begin
         errors++;
         $display("FAIL no_auto_armed: got done,busy,auto=%b expected 010", {capture_done, dump_busy, auto_trigd});
      end
`endif
      end_test("auto");
   endtask

   initial begin
      test_reset();
      test_capture(256, 0, 0, 1);
      repeat (3) test_capture($urandom_range(0, 511), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)));
      test_capture(0, 0, 1, 1);
      test_capture(511, 0, 0, 0);
      test_dump();
      test_decimation();
      test_fill_ignore();
      test_reset_mid();
      test_auto();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
